bus_mailbox: RTL and testbench

Memory-mapped byte mailbox that responds on the shared 19-bit tristate CPU bus, the target side of the bus-enabled CPU wrapper. It decodes a 4-byte register window and returns read data one cycle after the address. Behind the window sit a TX FIFO, drained by a far-side ready/valid stream, and an RX FIFO, filled by a far-side stream. It raises a level interrupt toward the CPU IRQ line.

---
 rtl/bus_mailbox.sv | 160 ++++++++++++++++
 tb/tb_bus_mailbox.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mailbox.sv
// Byte mailbox on the shared 19-bit CPU bus: DATA/STATUS/CONTROL/CLEAR window over TX and RX FIFOs.
// Define BUS_MAILBOX_IRQ_EN to implement CONTROL.IE and the irq output; otherwise irq is tied low.
module bus_mailbox #(
    parameter logic [18:0] BASE_ADDR  = 19'h0B800,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_valid,
    input  logic [18:0] AB,
    input  logic [7:0]  DI,
    input  logic        WE,
    output logic [7:0]  DO,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam int                    CW         = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [7:0]            rx_mem [DEPTH];
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_rd, rx_wr, tx_rd, tx_wr;
    logic [CW-1:0]         rx_count, tx_count, rx_count_nxt, tx_count_nxt;
    logic                  rx_ovf, tx_ovf, ie;
    logic                  resp_valid;
    logic [7:0]            resp_data, read_mux, status;

    logic       access, rd_access, wr_access;
    logic [1:0] sel;
    logic       rx_empty, rx_full, tx_full;
    logic       flush, clear;
    logic       rx_pop, rx_push, rx_drop;
    logic       tx_pop, tx_write, tx_push, tx_drop;

    assign access    = bus_valid && (AB[18:2] == BASE_ADDR[18:2]);
    assign sel       = AB[1:0];
    assign rd_access = access && !WE;
    assign wr_access = access && WE;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_COUNT);
    assign tx_full  = (tx_count == FULL_COUNT);
    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_mem[tx_rd];

    assign flush = wr_access && (sel == 2'd2) && DI[1];
    assign clear = wr_access && (sel == 2'd3);

    // A pop frees a slot at the same edge, so a full FIFO still accepts a concurrent push.
    assign rx_pop   = rd_access && (sel == 2'd0) && !rx_empty;
    assign rx_push  = rx_valid && (!rx_full || rx_pop) && !flush;
    assign rx_drop  = rx_valid && rx_full && !rx_pop && !flush;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_write = wr_access && (sel == 2'd0);
    assign tx_push  = tx_write && (!tx_full || tx_pop) && !flush;
    assign tx_drop  = tx_write && tx_full && !tx_pop && !flush;

    always_comb begin
        rx_count_nxt = flush ? '0 : rx_count + CW'(rx_push) - CW'(rx_pop);
        tx_count_nxt = flush ? '0 : tx_count + CW'(tx_push) - CW'(tx_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_rd    <= '0;
            rx_wr    <= '0;
            tx_rd    <= '0;
            tx_wr    <= '0;
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            rx_count <= rx_count_nxt;
            tx_count <= tx_count_nxt;
            if (flush) begin
                rx_rd <= '0;
                rx_wr <= '0;
                tx_rd <= '0;
                tx_wr <= '0;
            end else begin
                if (rx_push) rx_wr <= rx_wr + PTR_ONE;
                if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
                if (tx_push) tx_wr <= tx_wr + PTR_ONE;
                if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= rx_data;
        if (tx_push) tx_mem[tx_wr] <= DI;
    end

    // A drop on the same edge as CLEAR wins so that the overflow event is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ovf   <= 1'b0;
            tx_ovf   <= 1'b0;
            rx_ready <= 1'b0;
        end else begin
            rx_ready <= 1'b1;
            if (clear) begin
                rx_ovf <= 1'b0;
                tx_ovf <= 1'b0;
            end
            if (rx_drop) rx_ovf <= 1'b1;
            if (tx_drop) tx_ovf <= 1'b1;
        end
    end

`ifdef BUS_MAILBOX_IRQ_EN
    logic ie_nxt;
    assign ie_nxt = (wr_access && (sel == 2'd2)) ? DI[0] : ie;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            ie  <= ie_nxt;
            irq <= ie_nxt && (rx_count_nxt != '0);
        end
    end
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    assign status = {3'b000, irq, tx_ovf, rx_ovf, tx_full, !rx_empty};

    always_comb begin
        read_mux = 8'h00;
        case (sel)
            2'd0:    read_mux = rx_empty ? 8'h00 : rx_mem[rx_rd];
            2'd1:    read_mux = status;
            2'd2:    read_mux = {7'b0000000, ie};
            default: read_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_data  <= 8'h00;
        end else begin
            resp_valid <= rd_access;
            if (rd_access) resp_data <= read_mux;
        end
    end

    assign DO = resp_valid ? resp_data : 8'hzz;

endmodule

// File: tb/tb_bus_mailbox.sv
// Self-checking bench for bus_mailbox: bus reads are scored against a queue of expected bytes
// produced by a small FIFO/flag model of the mailbox.
module tb_bus_mailbox;

    localparam logic [18:0] BASE  = 19'h0B800;
    localparam int          DEPTH = 16;
`ifdef BUS_MAILBOX_IRQ_EN
    localparam logic        IRQ_ON = 1'b1;
`else
    localparam logic        IRQ_ON = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        bus_valid = 1'b0;
    logic [18:0] AB        = '0;
    logic [7:0]  DI        = '0;
    logic        WE        = 1'b0;
    wire  [7:0]  DO;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready  = 1'b0;
    logic [7:0]  rx_data   = '0;
    logic        rx_valid  = 1'b0;
    logic        rx_ready;

    int          check_count = 0;
    int          pass_count  = 0;
    logic [7:0]  rx_model[$];
    logic [7:0]  tx_model[$];
    logic [7:0]  exp_do_q[$];
    string       tag_q[$];
    bit          rx_ovf_exp   = 1'b0;
    bit          tx_ovf_exp   = 1'b0;
    bit          read_pending = 1'b0;
`ifdef BUS_MAILBOX_IRQ_EN
    bit          ie_exp = 1'b0;
`endif

    bus_mailbox dut (
        .clk      (clk),
        .reset    (reset),
        .bus_valid(bus_valid),
        .AB       (AB),
        .DI       (DI),
        .WE       (WE),
        .DO       (DO),
        .irq      (irq),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] exp_status();
        logic irq_e;
`ifdef BUS_MAILBOX_IRQ_EN
        irq_e = ie_exp && (rx_model.size() != 0);
`else
        irq_e = 1'b0;
`endif
        return {3'b000, irq_e, tx_ovf_exp, rx_ovf_exp,
                (tx_model.size() == DEPTH), (rx_model.size() != 0)};
    endfunction

    // Each call advances to the next falling edge and scores a read response issued at the edge just passed.
    task automatic tick();
        @(negedge clk);
        if (read_pending) begin
            read_pending = 1'b0;
            checkOutput(tag_q.pop_front(), DO, exp_do_q.pop_front());
        end
    endtask

    task automatic bus_write(input logic [1:0] reg_sel, input logic [7:0] data);
        case (reg_sel)
            2'd0: if (tx_model.size() < DEPTH) tx_model.push_back(data);
                  else tx_ovf_exp = 1'b1;
            2'd2: begin
`ifdef BUS_MAILBOX_IRQ_EN
                ie_exp = data[0];
`endif
                if (data[1]) begin
                    rx_model.delete();
                    tx_model.delete();
                end
            end
            2'd3: begin
                rx_ovf_exp = 1'b0;
                tx_ovf_exp = 1'b0;
            end
            default: ;
        endcase
        bus_valid = 1'b1;
        WE        = 1'b1;
        AB        = BASE | {17'b0, reg_sel};
        DI        = data;
        tick();
        bus_valid = 1'b0;
        WE        = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] reg_sel, input string tag);
        logic [7:0] exp;
        exp = 8'h00;
        case (reg_sel)
            2'd0: if (rx_model.size() != 0) exp = rx_model.pop_front();
            2'd1: exp = exp_status();
`ifdef BUS_MAILBOX_IRQ_EN
            2'd2: exp = {7'b0, ie_exp};
`endif
            default: exp = 8'h00;
        endcase
        exp_do_q.push_back(exp);
        tag_q.push_back(tag);
        bus_valid    = 1'b1;
        WE           = 1'b0;
        AB           = BASE | {17'b0, reg_sel};
        read_pending = 1'b1;
        tick();
        bus_valid = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] data);
        if (rx_model.size() < DEPTH) rx_model.push_back(data);
        else rx_ovf_exp = 1'b1;
        rx_valid = 1'b1;
        rx_data  = data;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus();
        // Reset state and the first STATUS read after release
        repeat (3) @(negedge clk);
        checkOutput("reset_do_z", DO, 8'hzz);
        checkOutput("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
        checkOutput("reset_irq", {7'b0, irq}, 8'h00);
        checkOutput("reset_rx_ready", {7'b0, rx_ready}, 8'h00);
        reset = 1'b1;
        tick();
        checkOutput("rx_ready_release", {7'b0, rx_ready}, 8'h01);
        checkOutput("do_z_before_read", DO, 8'hzz);
        bus_read(2'd1, "status_after_reset");
        tick();
        checkOutput("do_z_after_read", DO, 8'hzz);
        checkOutput("tx_valid_idle", {7'b0, tx_valid}, 8'h00);

        // TX stream with backpressure, then drain
        bus_write(2'd0, 8'hA5);
        bus_write(2'd0, 8'h3C);
        checkOutput("tx_valid_loaded", {7'b0, tx_valid}, 8'h01);
        checkOutput("tx_head", tx_data, 8'hA5);
        tick();
        checkOutput("tx_head_held", tx_data, 8'hA5);
        tx_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("tx_stream_valid", {7'b0, tx_valid}, 8'h01);
            checkOutput("tx_stream_data", tx_data, tx_model.pop_front());
            tick();
        end
        checkOutput("tx_drained", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;

        // RX overflow and back-to-back drain including a read of the empty FIFO
        for (int i = 1; i <= 17; i++) rx_push(8'(i));
        bus_read(2'd1, "status_rx_overflow");
        for (int i = 0; i < 17; i++) bus_read(2'd0, "rx_drain");
        tick();
        checkOutput("do_z_after_drain", DO, 8'hzz);
        bus_write(2'd3, 8'h00);

        // Interrupt on RX not empty
        bus_write(2'd2, 8'h01);
        rx_push(8'h77);
        checkOutput("irq_set", {7'b0, irq}, {7'b0, IRQ_ON});
        bus_read(2'd0, "rx_irq_byte");
        checkOutput("irq_clear", {7'b0, irq}, 8'h00);
        bus_write(2'd2, 8'h00);

        // TX overflow, CLEAR, FLUSH
        for (int i = 0; i < 16; i++) bus_write(2'd0, 8'(8'h40 + i));
        bus_write(2'd0, 8'hFF);
        bus_read(2'd1, "status_tx_overflow");
        bus_write(2'd3, 8'h5A);
        bus_read(2'd1, "status_after_clear");
        bus_write(2'd2, 8'h02);
        checkOutput("tx_valid_flushed", {7'b0, tx_valid}, 8'h00);
        bus_read(2'd1, "status_after_flush");
        bus_read(2'd2, "control_readback");

        // Pop and push on a full RX FIFO at the same edge: no overflow
        for (int i = 0; i < 16; i++) rx_push(8'(8'h20 + i));
        rx_valid = 1'b1;
        rx_data  = 8'h30;
        bus_read(2'd0, "rx_pop_push_full");
        rx_model.push_back(8'h30);
        rx_valid = 1'b0;
        bus_read(2'd1, "status_pop_push_full");
        bus_read(2'd0, "rx_after_pop_push");
        bus_write(2'd2, 8'h02);

        // Asynchronous reset during a DATA read response
        rx_push(8'h55);
        void'(rx_model.pop_front());
        bus_valid = 1'b1;
        WE        = 1'b0;
        AB        = BASE;
        @(posedge clk);
        #2;
        checkOutput("do_before_reset", DO, 8'h55);
        reset = 1'b0;
        #1;
        checkOutput("do_z_in_reset", DO, 8'hzz);
        checkOutput("tx_valid_in_reset", {7'b0, tx_valid}, 8'h00);
        checkOutput("rx_ready_in_reset", {7'b0, rx_ready}, 8'h00);
        checkOutput("irq_in_reset", {7'b0, irq}, 8'h00);
        bus_valid = 1'b0;
        rx_model.delete();
        tx_model.delete();
        rx_ovf_exp = 1'b0;
        tx_ovf_exp = 1'b0;
`ifdef BUS_MAILBOX_IRQ_EN
        ie_exp = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b1;
        bus_read(2'd1, "status_after_reset2");
        tick();
        checkOutput("do_z_final", DO, 8'hzz);
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
